// File: rtl/load_addr_queue.sv
// load_addr_queue
//   In-order load address-generation queue sitting between execute and the
//   load-data / load-buffer path. Each accepted issue packet has its
//   effective address, shifted byte mask and misalignment flag computed at
//   enqueue; up to DEPTH generated loads are held in a circular buffer and
//   presented one per cycle. Branch resolution squashes matching entries
//   (leaving holes that drain from the head) or clears their branch-mask bit.
//
// Ports
//   clock, reset            rising-edge clock, asynchronous active-high reset
//   in_valid / in_ready     issue handshake (in_ready may depend on out_ready)
//   in_base, in_offset      address operands, summed mod 2^ADDR_W
//   in_func                 [1:0] log2 access size, [2] unsigned load
//   in_dest, in_bm,
//   in_sq_tail              tag, branch mask and store-queue tail of the load
//   out_valid / out_ready   downstream handshake for the head entry
//   out_addr, out_byte_mask,
//   out_misaligned          generated address information
//   out_func, out_dest,
//   out_bm, out_sq_tail     passthrough fields (out_bm reflects a same-cycle
//                           correct resolution)
//   br_valid, br_mask,
//   br_mispredict           branch resolution, br_mask one-hot
//   count                   occupied slots, squashed holes included
module load_addr_queue #(
   parameter int DEPTH      = 4,
   parameter int ADDR_W     = 32,
   parameter int DATA_BYTES = 4,
   parameter int PREG_W     = 6,
   parameter int BM_W       = 4,
   parameter int SQ_W       = 3
) (
   input  logic                         clock,
   input  logic                         reset,
   input  logic                         in_valid,
   output logic                         in_ready,
   input  logic [ADDR_W-1:0]            in_base,
   input  logic [ADDR_W-1:0]            in_offset,
   input  logic [2:0]                   in_func,
   input  logic [PREG_W-1:0]            in_dest,
   input  logic [BM_W-1:0]              in_bm,
   input  logic [SQ_W-1:0]              in_sq_tail,
   output logic                         out_valid,
   input  logic                         out_ready,
   output logic [ADDR_W-1:0]            out_addr,
   output logic [DATA_BYTES-1:0]        out_byte_mask,
   output logic                         out_misaligned,
   output logic [2:0]                   out_func,
   output logic [PREG_W-1:0]            out_dest,
   output logic [BM_W-1:0]              out_bm,
   output logic [SQ_W-1:0]              out_sq_tail,
   input  logic                         br_valid,
   input  logic [BM_W-1:0]              br_mask,
   input  logic                         br_mispredict,
   output logic [$clog2(DEPTH+1)-1:0]   count
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int OFF_W = $clog2(DATA_BYTES);
   localparam int CNT_W = $clog2(DEPTH+1);

   // Byte lanes touched by an access of 2^size bytes starting at lane off.
   // Accesses wider than the memory word produce an empty mask.
   function automatic logic [DATA_BYTES-1:0] calc_mask(input logic [1:0] size,
                                                       input logic [OFF_W-1:0] off);
      logic [2*DATA_BYTES-1:0] span;
      int n;
      n    = 1 << size;
      span = '0;
      if (n <= DATA_BYTES) begin
         for (int i = 0; i < DATA_BYTES; i++) begin
            if (i < n) span[i] = 1'b1;
         end
         span = span << off;
      end
      return span[DATA_BYTES-1:0];
   endfunction

   function automatic logic calc_misaligned(input logic [1:0] size,
                                            input logic [OFF_W-1:0] off);
      int n;
      int offi;
      n    = 1 << size;
      offi = 32'(off);
      if (n > DATA_BYTES) return 1'b1;
      return (offi & (n - 1)) != 0;
   endfunction

   // ---- stage p0: address generation on the incoming packet ----
   logic [ADDR_W-1:0]     addr_p0;
   logic [DATA_BYTES-1:0] mask_p0;
   logic                  mis_p0;
   logic [BM_W-1:0]       bm_p0;

   // ---- stage p1: queue storage ----
   logic [DEPTH-1:0]      vld_p1;
   logic [ADDR_W-1:0]     addr_p1  [DEPTH];
   logic [DATA_BYTES-1:0] mask_p1  [DEPTH];
   logic                  mis_p1   [DEPTH];
   logic [2:0]            func_p1  [DEPTH];
   logic [PREG_W-1:0]     dest_p1  [DEPTH];
   logic [BM_W-1:0]       bm_p1    [DEPTH];
   logic [SQ_W-1:0]       sq_p1    [DEPTH];

   logic [PTR_W-1:0]      head_p1;
   logic [PTR_W-1:0]      tail_p1;

   logic                  br_squash;
   logic                  br_clear;
   logic                  head_kill;
   logic                  in_kill;
   logic                  pop;
   logic                  enq;
   logic [DEPTH-1:0]      squash_vec;
   logic [DEPTH-1:0]      vld_nxt;

   always_comb begin
      addr_p0 = in_base + in_offset;
      mask_p0 = calc_mask(in_func[1:0], addr_p0[OFF_W-1:0]);
      mis_p0  = calc_misaligned(in_func[1:0], addr_p0[OFF_W-1:0]);
      bm_p0   = br_clear ? (in_bm & ~br_mask) : in_bm;
   end

   always_comb begin
      br_squash = br_valid & br_mispredict;
      br_clear  = br_valid & ~br_mispredict;

      // A head being squashed this cycle is already treated as a hole, so it
      // is never offered downstream and pops at this edge.
      head_kill = br_squash & (|(bm_p1[head_p1] & br_mask));
      out_valid = vld_p1[head_p1] & ~head_kill;

      pop      = (count != '0) & (~out_valid | out_ready);
      in_ready = (count < CNT_W'(DEPTH)) | pop;

      // A packet tagged with the mispredicted branch is accepted but dropped.
      in_kill = br_squash & (|(in_bm & br_mask));
      enq     = in_valid & in_ready & ~in_kill;

      for (int i = 0; i < DEPTH; i++) begin
         squash_vec[i] = br_squash & (|(bm_p1[i] & br_mask));
      end

      // Enqueue is applied last: on a full queue with a pop, tail == head and
      // the new entry must own the slot.
      vld_nxt = vld_p1 & ~squash_vec;
      if (pop) vld_nxt[head_p1] = 1'b0;
      if (enq) vld_nxt[tail_p1] = 1'b1;
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         head_p1 <= '0;
         tail_p1 <= '0;
         count   <= '0;
         vld_p1  <= '0;
      end else begin
         vld_p1 <= vld_nxt;
         if (pop) head_p1 <= head_p1 + PTR_W'(1);
         if (enq) tail_p1 <= tail_p1 + PTR_W'(1);
         count <= count + CNT_W'(enq) - CNT_W'(pop);
      end
   end

   always_ff @(posedge clock) begin
      if (br_clear) begin
         for (int i = 0; i < DEPTH; i++) begin
            bm_p1[i] <= bm_p1[i] & ~br_mask;
         end
      end
      if (enq) begin
         addr_p1[tail_p1] <= addr_p0;
         mask_p1[tail_p1] <= mask_p0;
         mis_p1[tail_p1]  <= mis_p0;
         func_p1[tail_p1] <= in_func;
         dest_p1[tail_p1] <= in_dest;
         bm_p1[tail_p1]   <= bm_p0;
         sq_p1[tail_p1]   <= in_sq_tail;
      end
   end

   // ---- output: head entry, zeroed whenever it is not offered ----
   always_comb begin
      out_addr       = '0;
      out_byte_mask  = '0;
      out_misaligned = 1'b0;
      out_func       = '0;
      out_dest       = '0;
      out_bm         = '0;
      out_sq_tail    = '0;
      if (out_valid) begin
         out_addr       = addr_p1[head_p1];
         out_byte_mask  = mask_p1[head_p1];
         out_misaligned = mis_p1[head_p1];
         out_func       = func_p1[head_p1];
         out_dest       = dest_p1[head_p1];
         out_bm         = br_clear ? (bm_p1[head_p1] & ~br_mask) : bm_p1[head_p1];
         out_sq_tail    = sq_p1[head_p1];
      end
   end

endmodule

// File: tb/tb_load_addr_queue.sv
module tb_load_addr_queue;

   logic        clock;
   logic        reset;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_base;
   logic [31:0] in_offset;
   logic [2:0]  in_func;
   logic [5:0]  in_dest;
   logic [3:0]  in_bm;
   logic [2:0]  in_sq_tail;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_addr;
   logic [3:0]  out_byte_mask;
   logic        out_misaligned;
   logic [2:0]  out_func;
   logic [5:0]  out_dest;
   logic [3:0]  out_bm;
   logic [2:0]  out_sq_tail;
   logic        br_valid;
   logic [3:0]  br_mask;
   logic        br_mispredict;
   logic [2:0]  count;

   int errors = 0;
   int checks = 0;

   load_addr_queue #(
      .DEPTH(4), .ADDR_W(32), .DATA_BYTES(4), .PREG_W(6), .BM_W(4), .SQ_W(3)
   ) dut (
      .clock(clock), .reset(reset),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_base(in_base), .in_offset(in_offset), .in_func(in_func),
      .in_dest(in_dest), .in_bm(in_bm), .in_sq_tail(in_sq_tail),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_addr(out_addr), .out_byte_mask(out_byte_mask),
      .out_misaligned(out_misaligned), .out_func(out_func),
      .out_dest(out_dest), .out_bm(out_bm), .out_sq_tail(out_sq_tail),
      .br_valid(br_valid), .br_mask(br_mask), .br_mispredict(br_mispredict),
      .count(count)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic tick;
      @(posedge clock);
      #1;
   endtask

   task automatic set_in(input logic [31:0] base, input logic [31:0] offset,
                         input logic [2:0] func, input logic [5:0] dest,
                         input logic [3:0] bm, input logic [2:0] sq);
      in_valid   = 1'b1;
      in_base    = base;
      in_offset  = offset;
      in_func    = func;
      in_dest    = dest;
      in_bm      = bm;
      in_sq_tail = sq;
   endtask

   task automatic test_reset;
      tick;
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %0h want 0", out_valid); end
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %0h want 1", in_ready); end
      checks++; if (count !== 3'd0) begin errors++; $display("FAIL reset_count: got %0d want 0", count); end
      checks++; if (out_addr !== 32'h0) begin errors++; $display("FAIL reset_out_addr: got %0h want 0", out_addr); end
      checks++; if (out_byte_mask !== 4'h0) begin errors++; $display("FAIL reset_byte_mask: got %0h want 0", out_byte_mask); end
      reset = 1'b0;
   endtask

   task automatic test_single;
      out_ready = 1'b0;
      set_in(32'h1000, 32'h6, 3'd1, 6'd5, 4'h0, 3'd2);
      #1;
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL single_no_bypass: got %0h want 0", out_valid); end
      tick;
      in_valid = 1'b0;
      #1;
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL single_valid: got %0h want 1", out_valid); end
      checks++; if (out_addr !== 32'h1006) begin errors++; $display("FAIL single_addr: got %0h want 1006", out_addr); end
      checks++; if (out_byte_mask !== 4'b1100) begin errors++; $display("FAIL single_mask: got %b want 1100", out_byte_mask); end
      checks++; if (out_misaligned !== 1'b0) begin errors++; $display("FAIL single_mis: got %0h want 0", out_misaligned); end
      checks++; if (out_dest !== 6'd5) begin errors++; $display("FAIL single_dest: got %0d want 5", out_dest); end
      checks++; if (out_sq_tail !== 3'd2) begin errors++; $display("FAIL single_sq: got %0d want 2", out_sq_tail); end
      checks++; if (count !== 3'd1) begin errors++; $display("FAIL single_count: got %0d want 1", count); end
      out_ready = 1'b1;
      tick;
      checks++; if (count !== 3'd0) begin errors++; $display("FAIL single_drain_count: got %0d want 0", count); end
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL single_drain_valid: got %0h want 0", out_valid); end
   endtask

   task automatic test_misalign;
      out_ready = 1'b0;
      set_in(32'h1001, 32'h0, 3'd2, 6'd7, 4'h0, 3'd0);
      tick;
      set_in(32'h1001, 32'h0, 3'd3, 6'd8, 4'h0, 3'd0);
      #1;
      checks++; if (out_byte_mask !== 4'b1110) begin errors++; $display("FAIL mis_word_mask: got %b want 1110", out_byte_mask); end
      checks++; if (out_misaligned !== 1'b1) begin errors++; $display("FAIL mis_word_flag: got %0h want 1", out_misaligned); end
      checks++; if (out_func !== 3'd2) begin errors++; $display("FAIL mis_word_func: got %0d want 2", out_func); end
      out_ready = 1'b1;
      tick;
      in_valid = 1'b0;
      #1;
      checks++; if (out_byte_mask !== 4'b0000) begin errors++; $display("FAIL mis_dbl_mask: got %b want 0000", out_byte_mask); end
      checks++; if (out_misaligned !== 1'b1) begin errors++; $display("FAIL mis_dbl_flag: got %0h want 1", out_misaligned); end
      checks++; if (out_dest !== 6'd8) begin errors++; $display("FAIL mis_dbl_dest: got %0d want 8", out_dest); end
      checks++; if (count !== 3'd1) begin errors++; $display("FAIL mis_count: got %0d want 1", count); end
      tick;
      checks++; if (count !== 3'd0) begin errors++; $display("FAIL mis_drain: got %0d want 0", count); end
   endtask

   task automatic test_fill;
      out_ready = 1'b0;
      for (int i = 1; i <= 4; i++) begin
         set_in(32'h100 * i, 32'h0, 3'd2, 6'(i), 4'h0, 3'd0);
         tick;
      end
      set_in(32'h500, 32'h0, 3'd2, 6'd5, 4'h0, 3'd0);
      #1;
      checks++; if (count !== 3'd4) begin errors++; $display("FAIL fill_count: got %0d want 4", count); end
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL fill_in_ready_low: got %0h want 0", in_ready); end
      checks++; if (out_dest !== 6'd1) begin errors++; $display("FAIL fill_head: got %0d want 1", out_dest); end
      out_ready = 1'b1;
      #1;
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL fill_in_ready_pop: got %0h want 1", in_ready); end
      tick;
      in_valid = 1'b0;
      #1;
      checks++; if (count !== 3'd4) begin errors++; $display("FAIL fill_count_swap: got %0d want 4", count); end
      for (int d = 2; d <= 5; d++) begin
         checks++; if (out_valid !== 1'b1 || out_dest !== 6'(d)) begin
            errors++; $display("FAIL fill_order: got valid=%0h dest=%0d want valid=1 dest=%0d", out_valid, out_dest, d);
         end
         checks++; if (out_addr !== 32'h100 * d) begin errors++; $display("FAIL fill_addr: got %0h want %0h", out_addr, 32'h100 * d); end
         tick;
      end
      checks++; if (count !== 3'd0) begin errors++; $display("FAIL fill_drain: got %0d want 0", count); end
   endtask

   task automatic test_mispredict;
      out_ready = 1'b0;
      set_in(32'h2000, 32'h0, 3'd2, 6'd10, 4'b0001, 3'd0); tick;
      set_in(32'h2004, 32'h0, 3'd2, 6'd11, 4'b0010, 3'd0); tick;
      set_in(32'h2008, 32'h0, 3'd2, 6'd12, 4'b0001, 3'd0); tick;
      set_in(32'h200c, 32'h0, 3'd2, 6'd13, 4'b0001, 3'd0);
      br_valid = 1'b1; br_mask = 4'b0001; br_mispredict = 1'b1;
      #1;
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL mp_head_killed: got %0h want 0", out_valid); end
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL mp_in_ready: got %0h want 1", in_ready); end
      checks++; if (count !== 3'd3) begin errors++; $display("FAIL mp_count_pre: got %0d want 3", count); end
      tick;
      br_valid = 1'b0; br_mispredict = 1'b0; br_mask = 4'b0000;
      in_valid = 1'b0;
      out_ready = 1'b1;
      #1;
      checks++; if (count !== 3'd2) begin errors++; $display("FAIL mp_count_post: got %0d want 2", count); end
      checks++; if (out_valid !== 1'b1 || out_dest !== 6'd11) begin
         errors++; $display("FAIL mp_survivor: got valid=%0h dest=%0d want valid=1 dest=11", out_valid, out_dest);
      end
      checks++; if (out_bm !== 4'b0010) begin errors++; $display("FAIL mp_survivor_bm: got %b want 0010", out_bm); end
      tick;
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL mp_hole_tail: got %0h want 0", out_valid); end
      checks++; if (count !== 3'd1) begin errors++; $display("FAIL mp_count_hole: got %0d want 1", count); end
      tick;
      checks++; if (count !== 3'd0) begin errors++; $display("FAIL mp_drained: got %0d want 0", count); end
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL mp_no_extra: got %0h want 0", out_valid); end
   endtask

   task automatic test_correct;
      out_ready = 1'b0;
      set_in(32'h3000, 32'h0, 3'd2, 6'd20, 4'b0011, 3'd1); tick;
      set_in(32'h3004, 32'h0, 3'd2, 6'd21, 4'b0011, 3'd1);
      br_valid = 1'b1; br_mask = 4'b0001; br_mispredict = 1'b0;
      #1;
      checks++; if (out_bm !== 4'b0010) begin errors++; $display("FAIL cr_same_cycle_bm: got %b want 0010", out_bm); end
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL cr_valid: got %0h want 1", out_valid); end
      tick;
      br_valid = 1'b0; br_mask = 4'b0000;
      in_valid = 1'b0;
      #1;
      checks++; if (out_bm !== 4'b0010 || out_dest !== 6'd20) begin
         errors++; $display("FAIL cr_first: got bm=%b dest=%0d want bm=0010 dest=20", out_bm, out_dest);
      end
      checks++; if (count !== 3'd2) begin errors++; $display("FAIL cr_count: got %0d want 2", count); end
      out_ready = 1'b1;
      tick;
      checks++; if (out_bm !== 4'b0010 || out_dest !== 6'd21) begin
         errors++; $display("FAIL cr_incoming: got bm=%b dest=%0d want bm=0010 dest=21", out_bm, out_dest);
      end
      tick;
      checks++; if (count !== 3'd0) begin errors++; $display("FAIL cr_drain: got %0d want 0", count); end
   endtask

   task automatic test_back_to_back;
      out_ready = 1'b1;
      for (int i = 0; i < 6; i++) begin
         set_in(32'h4000, 32'(i * 4), 3'd2, 6'(30 + i), 4'h0, 3'd0);
         tick;
         checks++; if (out_valid !== 1'b1 || out_dest !== 6'(30 + i) || count !== 3'd1) begin
            errors++; $display("FAIL b2b_stream: got valid=%0h dest=%0d count=%0d want valid=1 dest=%0d count=1",
                               out_valid, out_dest, count, 30 + i);
         end
      end
      in_valid = 1'b0;
      tick;
      checks++; if (count !== 3'd0) begin errors++; $display("FAIL b2b_drain: got %0d want 0", count); end
   endtask

   task automatic test_async_reset;
      out_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         set_in(32'h5000, 32'(i), 3'd0, 6'(40 + i), 4'h0, 3'd0);
         tick;
      end
      in_valid = 1'b0;
      #1;
      checks++; if (count !== 3'd3 || out_valid !== 1'b1) begin
         errors++; $display("FAIL ar_pre: got count=%0d valid=%0h want count=3 valid=1", count, out_valid);
      end
      #2;
      reset = 1'b1;
      #1;
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL ar_valid: got %0h want 0", out_valid); end
      checks++; if (count !== 3'd0) begin errors++; $display("FAIL ar_count: got %0d want 0", count); end
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL ar_in_ready: got %0h want 1", in_ready); end
      #1;
      reset = 1'b0;
      out_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         tick;
         checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL ar_after: got %0h want 0", out_valid); end
      end
   endtask

   initial begin
      reset = 1'b1;
      in_valid = 1'b0; in_base = '0; in_offset = '0; in_func = '0;
      in_dest = '0; in_bm = '0; in_sq_tail = '0;
      out_ready = 1'b0;
      br_valid = 1'b0; br_mask = '0; br_mispredict = 1'b0;
      test_reset;
      test_single;
      test_misalign;
      test_fill;
      test_mispredict;
      test_correct;
      test_back_to_back;
      test_async_reset;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
